// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
// Shared types and constants for the sequence-entry checker.
//   state_e     : FSM states of the entry session
//   DIGIT_W     : width of one sequence digit
//   BTN_N       : number of push-buttons (one per digit value)
//   SEQ_LEN_DEF : default number of entries per sequence
//   btn_index() : index of the set bit in a one-hot button vector
// -----------------------------------------------------------------------------
package seq_pkg;

  localparam int DIGIT_W     = 4;
  localparam int BTN_N       = 4;
  localparam int SEQ_LEN_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_PRESS,
    ST_CHECK,
    ST_WAIT_RELEASE,
    ST_PASS,
    ST_FAIL
  } state_e;

  // Caller guarantees exactly one bit is set; returns its position.
  function automatic logic [1:0] btn_index(input logic [BTN_N-1:0] btn);
    btn_index = '0;
    for (int k = 0; k < BTN_N; k++) begin
      if (btn[k]) btn_index = 2'(k);
    end
  endfunction

endpackage

// File: rtl/seq_entry_check_if.sv
// -----------------------------------------------------------------------------
// seq_entry_check_if
// Bundles the user-side buttons, session control and result outputs.
//   BTN       : raw asynchronous buttons, bit k = digit k
//   START     : one-cycle pulse, latches EXP_SEQ and begins a session
//   EXP_SEQ   : expected digits, entry n at [4n+3:4n]
//   BUSY      : session active
//   DIGIT     : last accepted digit
//   DIGIT_VLD : one-cycle pulse per accepted press
//   COUNT     : correct entries in the current session
//   PASS/FAIL : one-cycle result pulses
// master drives stimulus (system side), slave is the checker.
// -----------------------------------------------------------------------------
interface seq_entry_check_if
  import seq_pkg::*;
#(
  parameter int SEQ_LEN = SEQ_LEN_DEF
);

  logic [BTN_N-1:0]           BTN;
  logic                       START;
  logic [DIGIT_W*SEQ_LEN-1:0] EXP_SEQ;
  logic                       BUSY;
  logic [DIGIT_W-1:0]         DIGIT;
  logic                       DIGIT_VLD;
  logic [3:0]                 COUNT;
  logic                       PASS;
  logic                       FAIL;

  modport master (
    output BTN, START, EXP_SEQ,
    input  BUSY, DIGIT, DIGIT_VLD, COUNT, PASS, FAIL
  );

  modport slave (
    input  BTN, START, EXP_SEQ,
    output BUSY, DIGIT, DIGIT_VLD, COUNT, PASS, FAIL
  );

endinterface

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Debounces one raw asynchronous button bit.
//   CLK, RST_N : clock, async active-low reset
//   btn_raw    : raw button level
//   btn_db     : debounced level, follows btn_raw after CYCLES stable samples
// A raw edge reaches btn_db after 2 (synchronizer) + CYCLES clocks.
// -----------------------------------------------------------------------------
module btn_debounce #(
  parameter int CYCLES = 100000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic btn_raw,
  output logic btn_db
);

  localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] stable_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values; blocking here would collapse the sync chain.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_q     <= '0;
      stable_cnt <= '0;
      btn_db     <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_raw};
      // Counting samples that differ from the current level; any sample
      // equal to the level breaks the run and restarts the count.
      if (sync_q[1] == btn_db) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CNT_W'(CYCLES - 1)) begin
        btn_db     <= sync_q[1];
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_entry_check.sv
// -----------------------------------------------------------------------------
// seq_entry_check
// Debounces four buttons and checks a typed digit sequence against the
// sequence latched at START; reports each accepted digit and a final
// PASS or FAIL pulse.
//   CLK, RST_N : clock, async active-low reset
//   bus        : seq_entry_check_if.slave (buttons, START/EXP_SEQ, results)
// Outputs are decoded from state (DIGIT_VLD in CHECK, PASS/FAIL in their
// one-cycle states) or come straight from holding registers.
// -----------------------------------------------------------------------------
module seq_entry_check
  import seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int TIMEOUT_CYCLES  = 500000000,
  parameter int SEQ_LEN         = SEQ_LEN_DEF
) (
  input logic              CLK,
  input logic              RST_N,
  seq_entry_check_if.slave bus
);

  localparam int IDX_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_e                     state, next_state;
  logic [BTN_N-1:0]           db, db_q;
  logic                       press_evt;
  logic [DIGIT_W*SEQ_LEN-1:0] exp_q;
  logic [DIGIT_W-1:0]         exp_digit;
  logic [IDX_W-1:0]           idx;
  logic                       last_entry;
  logic [3:0]                 count_q;
  logic [DIGIT_W-1:0]         digit_q;
  logic [TMR_W-1:0]           timer;

  // Control strobes from the FSM to the datapath.
  logic session_clr, latch_digit, hit, timer_clr;

  for (genvar k = 0; k < BTN_N; k++) begin : g_db
    btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .btn_raw (bus.BTN[k]),
      .btn_db  (db[k])
    );
  end

  // Only rising debounced edges count, so a button held across START or
  // through WAIT_RELEASE never fires until released and pressed again.
  assign press_evt  = |(db & ~db_q);
  assign exp_digit  = exp_q[idx*DIGIT_W +: DIGIT_W];
  assign last_entry = (idx == IDX_W'(SEQ_LEN - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= next_state;
  end

  // NOTE: every output of this block gets a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    next_state  = state;
    session_clr = 1'b0;
    latch_digit = 1'b0;
    hit         = 1'b0;
    timer_clr   = 1'b0;
    if (bus.START) begin
      // START overrides any press, timeout or result in flight.
      next_state  = ST_WAIT_PRESS;
      session_clr = 1'b1;
    end else begin
      unique case (state)
        ST_IDLE: ;
        ST_WAIT_PRESS: begin
          if (press_evt && $countones(db) == 1) begin
            latch_digit = 1'b1;
            next_state  = ST_CHECK;
          end else if (press_evt) begin
            next_state = ST_FAIL;
          end else if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
            next_state = ST_FAIL;
          end
        end
        ST_CHECK: begin
          // Expected digits with upper bits set never equal a button index.
          if (digit_q == exp_digit) begin
            hit        = 1'b1;
            next_state = last_entry ? ST_PASS : ST_WAIT_RELEASE;
          end else begin
            next_state = ST_FAIL;
          end
        end
        ST_WAIT_RELEASE: begin
          if (db == '0) begin
            timer_clr  = 1'b1;
            next_state = ST_WAIT_PRESS;
          end
        end
        ST_PASS, ST_FAIL: next_state = ST_IDLE;
        default:          next_state = ST_IDLE;
      endcase
    end
  end

  // NOTE: the latched sequence is an ordinary register bank and is reset
  // with everything else, so outputs and compares are defined from reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      db_q    <= '0;
      exp_q   <= '0;
      idx     <= '0;
      count_q <= '0;
      digit_q <= '0;
      timer   <= '0;
    end else begin
      db_q <= db;
      if (session_clr) begin
        exp_q   <= bus.EXP_SEQ;
        idx     <= '0;
        count_q <= '0;
        timer   <= '0;
      end else begin
        if (timer_clr)                    timer <= '0;
        else if (state == ST_WAIT_PRESS)  timer <= timer + 1'b1;
        if (latch_digit) digit_q <= DIGIT_W'(btn_index(db));
        if (hit) begin
          count_q <= count_q + 4'd1;
          if (!last_entry) idx <= idx + 1'b1;
        end
      end
    end
  end

  assign bus.BUSY      = (state == ST_WAIT_PRESS) || (state == ST_CHECK) ||
                         (state == ST_WAIT_RELEASE);
  assign bus.DIGIT     = digit_q;
  assign bus.DIGIT_VLD = (state == ST_CHECK);
  assign bus.COUNT     = count_q;
  assign bus.PASS      = (state == ST_PASS);
  assign bus.FAIL      = (state == ST_FAIL);

endmodule

// File: tb/tb_seq_entry_check.sv
// -----------------------------------------------------------------------------
// tb_seq_entry_check
// Scoreboard bench: each stimulus task pushes the events it should cause
// (digit, pass, fail) with their expected cycle; a negedge monitor pops and
// compares whenever the DUT pulses DIGIT_VLD, PASS or FAIL.
// -----------------------------------------------------------------------------
module tb_seq_entry_check;

  localparam int DEB     = 4;
  localparam int TMO     = 50;
  localparam int SEQ_LEN = 4;

  localparam int EV_NONE  = 0;
  localparam int EV_DIGIT = 1;
  localparam int EV_PASS  = 2;
  localparam int EV_FAIL  = 3;

  typedef struct {
    int kind;
    int digit;
    int count;
    int at;   // absolute monitor cycle, -1 = don't care
    int gap;  // cycles after previous event, -1 = don't care
  } ev_t;

  logic CLK;
  logic RST_N;
  int   cyc;
  int   last_cyc;
  int   n_checks;
  int   n_fail;
  ev_t  sb[$];

  // Reference model of the running session.
  logic [15:0] m_exp;
  int          m_idx;
  int          m_count;
  bit          m_live;

  seq_entry_check_if #(.SEQ_LEN(SEQ_LEN)) bus ();

  seq_entry_check #(
    .DEBOUNCE_CYCLES (DEB),
    .TIMEOUT_CYCLES  (TMO),
    .SEQ_LEN         (SEQ_LEN)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void expect_ev(int kind, int digit, int count, int at, int gap);
    ev_t e;
    e.kind = kind; e.digit = digit; e.count = count; e.at = at; e.gap = gap;
    sb.push_back(e);
  endfunction

  task automatic on_event();
    ev_t e;
    int  obs;
    obs = bus.DIGIT_VLD ? EV_DIGIT : (bus.PASS ? EV_PASS : EV_FAIL);
    if (sb.size() > 0) begin
      e = sb.pop_front();
    end else begin
      e.kind = EV_NONE; e.digit = 0; e.count = 0; e.at = -1; e.gap = -1;
    end
    check("event_kind", obs, e.kind);
    check("single_pulse", int'(bus.DIGIT_VLD) + int'(bus.PASS) + int'(bus.FAIL), 1);
    if (e.kind != EV_NONE) begin
      if (e.kind == EV_DIGIT) check("digit", int'(bus.DIGIT), e.digit);
      check("count", int'(bus.COUNT), e.count);
      check("busy_at_event", int'(bus.BUSY), int'(e.kind == EV_DIGIT));
      if (e.at >= 0)  check("event_cycle", cyc, e.at);
      if (e.gap >= 0) check("event_gap", cyc - last_cyc, e.gap);
    end
  endtask

  always @(negedge CLK) begin
    if (RST_N && (bus.DIGIT_VLD || bus.PASS || bus.FAIL)) begin
      on_event();
      last_cyc <= cyc;
    end
  end

  // Returns the cycle of the edge that moves the DUT into WAIT_PRESS.
  task automatic pulse_start(input logic [15:0] e, output int entry_cyc);
    @(negedge CLK);
    bus.EXP_SEQ = e;
    bus.START   = 1'b1;
    entry_cyc   = cyc + 1;
    @(negedge CLK);
    bus.START = 1'b0;
    m_exp   = e;
    m_idx   = 0;
    m_count = 0;
    m_live  = 1'b1;
  endtask

  // Press single digit d for 10 cycles, release, idle 10 cycles.
  task automatic press_one(input int d, output int rel);
    int c;
    int want;
    @(negedge CLK);
    bus.BTN = 4'(1 << d);
    c = cyc;
    if (m_live) begin
      want = int'((m_exp >> (4 * m_idx)) & 16'hF);
      expect_ev(EV_DIGIT, d, m_count, c + 2 + DEB + 1, -1);
      if (want == d) begin
        m_count++;
        if (m_idx == SEQ_LEN - 1) begin
          expect_ev(EV_PASS, 0, m_count, -1, 1);
          m_live = 1'b0;
        end else begin
          m_idx++;
        end
      end else begin
        expect_ev(EV_FAIL, 0, m_count, -1, 1);
        m_live = 1'b0;
      end
    end
    repeat (10) @(negedge CLK);
    bus.BTN = '0;
    rel = cyc;
    repeat (10) @(negedge CLK);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check("sb_drain", sb.size(), 0);
    repeat (3) @(negedge CLK);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    int rel;
    n_checks    = 0;
    n_fail      = 0;
    last_cyc    = 0;
    m_live      = 1'b0;
    m_exp       = '0;
    m_idx       = 0;
    m_count     = 0;
    RST_N       = 1'b0;
    bus.BTN     = '0;
    bus.START   = 1'b0;
    bus.EXP_SEQ = '0;
    repeat (3) @(negedge CLK);
    check("reset_outputs",
          int'({bus.BUSY, bus.DIGIT, bus.COUNT, bus.DIGIT_VLD, bus.PASS, bus.FAIL}), 0);
    RST_N = 1'b1;
    repeat (3) @(negedge CLK);
    check("idle_busy", int'(bus.BUSY), 0);

    // Full correct sequence 0,2,1,3.
    pulse_start(16'h3120, t);
    check("busy_after_start", int'(bus.BUSY), 1);
    press_one(0, rel);
    press_one(2, rel);
    press_one(1, rel);
    press_one(3, rel);
    drain(100);
    check("pass_count_hold", int'(bus.COUNT), 4);
    check("pass_digit_hold", int'(bus.DIGIT), 3);
    check("pass_busy_low", int'(bus.BUSY), 0);

    // Mismatch on the second entry.
    pulse_start(16'h3120, t);
    press_one(0, rel);
    press_one(1, rel);
    drain(100);
    check("fail_count_hold", int'(bus.COUNT), 1);

    // No input: timeout exactly TMO cycles after entering WAIT_PRESS.
    pulse_start(16'h3120, t);
    expect_ev(EV_FAIL, 0, 0, t + TMO, -1);
    drain(TMO + 20);

    // Bouncing input filtered, then a clean press; then timeout again.
    pulse_start(16'h3120, t);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      bus.BTN[0] = ~bus.BTN[0];
      @(negedge CLK);
    end
    bus.BTN = '0;
    repeat (6) @(negedge CLK);
    press_one(0, rel);
    // WAIT_RELEASE ends 2+DEB+1 edges after release; timer restarts there.
    expect_ev(EV_FAIL, 0, 1, rel + 2 + DEB + 1 + TMO, -1);
    drain(TMO + 20);

    // Two buttons together.
    pulse_start(16'h3120, t);
    @(negedge CLK);
    bus.BTN = 4'b0110;
    expect_ev(EV_FAIL, 0, 0, cyc + 2 + DEB + 1, -1);
    repeat (10) @(negedge CLK);
    bus.BTN = '0;
    repeat (10) @(negedge CLK);
    drain(20);

    // Asynchronous reset mid-session.
    pulse_start(16'h3120, t);
    press_one(0, rel);
    press_one(2, rel);
    drain(20);
    check("pre_reset_count", int'(bus.COUNT), 2);
    check("pre_reset_busy", int'(bus.BUSY), 1);
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    check("async_reset_outputs",
          int'({bus.BUSY, bus.DIGIT, bus.COUNT, bus.DIGIT_VLD, bus.PASS, bus.FAIL}), 0);
    m_live = 1'b0;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    pulse_start(16'h3120, t);
    expect_ev(EV_FAIL, 0, 0, t + TMO, -1);
    check("post_reset_count", int'(bus.COUNT), 0);
    check("post_reset_busy", int'(bus.BUSY), 1);
    drain(TMO + 20);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
